// File: rtl/f8_ifetch.sv
// f8_ifetch: instruction prefetch stage for the f8 core.
//
// Issues 3-byte fetches to the memory instruction port. Returned words go into a byte queue, and
// a 3-byte window at the queue head is presented to the decoder. The decoder consumes 0..3 bytes
// per cycle. A redirect flushes the queue and any fetch in flight.
//
// Ports:
//   clk          clock, all state on posedge
//   reset        asynchronous active-high reset
//   iread_addr   fetch address to the memory port (fetch_pc register)
//   iread_data   returned bytes: [7:0]=addr, [15:8]=addr+1, [23:16]=addr+2 (1-cycle latency)
//   iread_valid  qualifies iread_data in the cycle after an issue
//   instr_data   window at the queue head, [7:0] = byte at instr_pc
//   instr_avail  valid bytes in the window, min(count, 3)
//   instr_pc     address of instr_data[7:0]
//   consume      bytes taken by the decoder this cycle (clamped to instr_avail)
//   redirect     flush and restart fetch at redirect_pc
//   redirect_pc  new fetch address
//
// Optional feature: define IFETCH_BYPASS_EN so that a response arriving into an empty queue is
// shown on the window in its arrival cycle.

module f8_ifetch #(
  parameter int unsigned QBYTES   = 8,
  parameter logic [15:0] RESET_PC = 16'h4000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] iread_addr,
  input  logic [23:0] iread_data,
  input  logic        iread_valid,
  output logic [23:0] instr_data,
  output logic [1:0]  instr_avail,
  output logic [15:0] instr_pc,
  input  logic [1:0]  consume,
  input  logic        redirect,
  input  logic [15:0] redirect_pc
);

  localparam int unsigned PW = $clog2(QBYTES);
  localparam int unsigned CW = PW + 1;
  // Wide enough for count + 6 without overflow.
  localparam int unsigned RW = CW + 2;

  typedef enum logic {StIdle, StInflight} state_e;

  state_e          state_q, state_d;
  logic [15:0]     fetch_pc_q, fetch_pc_d;
  logic [15:0]     pend_addr_q, pend_addr_d;
  logic [15:0]     instr_pc_q, instr_pc_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [7:0]      mem_q [QBYTES];

  logic            pending;
  logic            accept;
  logic            replay;
  logic            issue;
  logic            bypass;
  logic [1:0]      q_avail;
  logic [1:0]      consume_eff;
  logic [RW-1:0]   room_need;
  logic [23:0]     q_window;

  assign pending = (state_q == StInflight);
  assign accept  = pending && iread_valid && !redirect;
  assign replay  = pending && !iread_valid && !redirect;

`ifdef IFETCH_BYPASS_EN
  assign bypass = accept && (count_q == '0);
`else
  assign bypass = 1'b0;
`endif

  assign q_avail  = (count_q >= CW'(3)) ? 2'd3 : count_q[1:0];
  assign q_window = {mem_q[rd_ptr_q + PW'(2)], mem_q[rd_ptr_q + PW'(1)], mem_q[rd_ptr_q]};

  always_comb begin
    instr_avail = q_avail;
    instr_data  = q_window;
    if (bypass) begin
      instr_avail = 2'd3;
      instr_data  = iread_data;
    end
  end

  assign consume_eff = redirect ? 2'd0 : ((consume > instr_avail) ? instr_avail : consume);

  // Space check counts the bytes already in flight so an accepted response can never overflow.
  assign room_need = RW'(count_q) - RW'(consume_eff) + (pending ? RW'(6) : RW'(3));
  assign issue     = !redirect && !replay && (room_need <= RW'(QBYTES));

  always_comb begin
    state_d     = issue ? StInflight : StIdle;
    pend_addr_d = issue ? fetch_pc_q : pend_addr_q;
    fetch_pc_d  = fetch_pc_q;
    instr_pc_d  = instr_pc_q + 16'(consume_eff);
    count_d     = count_q + (accept ? CW'(3) : CW'(0)) - CW'(consume_eff);
    rd_ptr_d    = rd_ptr_q + PW'(consume_eff);
    wr_ptr_d    = wr_ptr_q + (accept ? PW'(3) : PW'(0));
    if (redirect) begin
      fetch_pc_d = redirect_pc;
      instr_pc_d = redirect_pc;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else if (replay) begin
      // Dropped response: refetch the same address.
      fetch_pc_d = pend_addr_q;
    end else if (issue) begin
      fetch_pc_d = fetch_pc_q + 16'd3;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      fetch_pc_q  <= RESET_PC;
      pend_addr_q <= RESET_PC;
      instr_pc_q  <= RESET_PC;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      pend_addr_q <= pend_addr_d;
      instr_pc_q  <= instr_pc_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
    end
  end

  // Queue storage; in bypass mode the bytes are written even if consumed in the same cycle,
  // since rd_ptr advances past them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(QBYTES); i++) begin
        mem_q[i] <= 8'h00;
      end
    end else if (accept) begin
      mem_q[wr_ptr_q]          <= iread_data[7:0];
      mem_q[wr_ptr_q + PW'(1)] <= iread_data[15:8];
      mem_q[wr_ptr_q + PW'(2)] <= iread_data[23:16];
    end
  end

  assign iread_addr = fetch_pc_q;
  assign instr_pc   = instr_pc_q;

  // Decoder must never take more bytes than the window shows.
  assert property (@(posedge clk) disable iff (reset) !redirect |-> (consume <= instr_avail));

endmodule

// File: tb/tb_f8_ifetch.sv
// Directed, table-driven bench for f8_ifetch (QBYTES=8, RESET_PC=4000).
// Memory model returns byte[a] = a[7:0] with one cycle of latency.

module tb_f8_ifetch;

  logic        clk;
  logic        reset;
  logic [15:0] iread_addr;
  logic [23:0] iread_data;
  logic        iread_valid;
  logic [23:0] instr_data;
  logic [1:0]  instr_avail;
  logic [15:0] instr_pc;
  logic [1:0]  consume;
  logic        redirect;
  logic [15:0] redirect_pc;

  int n_cmp = 0;
  int n_bad = 0;

  f8_ifetch #(
    .QBYTES   (8),
    .RESET_PC (16'h4000)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .iread_addr  (iread_addr),
    .iread_data  (iread_data),
    .iread_valid (iread_valid),
    .instr_data  (instr_data),
    .instr_avail (instr_avail),
    .instr_pc    (instr_pc),
    .consume     (consume),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Registered memory: data for the address presented in the previous cycle.
  always @(posedge clk) begin
    iread_data <= {iread_addr[7:0] + 8'd2, iread_addr[7:0] + 8'd1, iread_addr[7:0]};
  end

  typedef struct {
    logic [1:0]  c;
    logic        r;
    logic [15:0] rpc;
    logic        v;
    logic [15:0] addr;
    logic [1:0]  avail;
    logic [15:0] pc;
    logic [23:0] data;
    logic        cd;
  } vec_t;

  vec_t vt [20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //          c     r     rpc       v     addr      avail  pc        data        cd
    vt[0]  = '{2'd0, 1'b0, 16'h0000, 1'b1, 16'h4003, 2'd0, 16'h4000, 24'h000000, 1'b1};
    vt[1]  = '{2'd0, 1'b0, 16'h0000, 1'b1, 16'h4006, 2'd3, 16'h4000, 24'h020100, 1'b1};
    vt[2]  = '{2'd0, 1'b0, 16'h0000, 1'b1, 16'h4006, 2'd3, 16'h4000, 24'h020100, 1'b1};
    vt[3]  = '{2'd0, 1'b0, 16'h0000, 1'b1, 16'h4006, 2'd3, 16'h4000, 24'h020100, 1'b1};
    vt[4]  = '{2'd3, 1'b0, 16'h0000, 1'b1, 16'h4009, 2'd3, 16'h4003, 24'h050403, 1'b1};
    vt[5]  = '{2'd3, 1'b0, 16'h0000, 1'b1, 16'h400C, 2'd3, 16'h4006, 24'h080706, 1'b1};
    vt[6]  = '{2'd3, 1'b0, 16'h0000, 1'b1, 16'h400F, 2'd3, 16'h4009, 24'h0B0A09, 1'b1};
    vt[7]  = '{2'd0, 1'b0, 16'h0000, 1'b0, 16'h400C, 2'd3, 16'h4009, 24'h0B0A09, 1'b1};
    vt[8]  = '{2'd0, 1'b0, 16'h0000, 1'b1, 16'h400F, 2'd3, 16'h4009, 24'h0B0A09, 1'b1};
    vt[9]  = '{2'd1, 1'b0, 16'h0000, 1'b1, 16'h4012, 2'd3, 16'h400A, 24'h0C0B0A, 1'b1};
    vt[10] = '{2'd2, 1'b0, 16'h0000, 1'b1, 16'h4012, 2'd3, 16'h400C, 24'h0E0D0C, 1'b1};
    vt[11] = '{2'd1, 1'b0, 16'h0000, 1'b1, 16'h4015, 2'd3, 16'h400D, 24'h0F0E0D, 1'b1};
    vt[12] = '{2'd3, 1'b0, 16'h0000, 1'b1, 16'h4018, 2'd3, 16'h4010, 24'h121110, 1'b1};
    vt[13] = '{2'd3, 1'b1, 16'hFFFE, 1'b1, 16'hFFFE, 2'd0, 16'hFFFE, 24'h000000, 1'b0};
    vt[14] = '{2'd0, 1'b0, 16'h0000, 1'b1, 16'h0001, 2'd0, 16'hFFFE, 24'h000000, 1'b0};
    vt[15] = '{2'd0, 1'b0, 16'h0000, 1'b1, 16'h0004, 2'd3, 16'hFFFE, 24'h00FFFE, 1'b1};
    vt[16] = '{2'd1, 1'b0, 16'h0000, 1'b1, 16'h0007, 2'd3, 16'hFFFF, 24'h0100FF, 1'b1};
    vt[17] = '{2'd1, 1'b0, 16'h0000, 1'b1, 16'h0007, 2'd3, 16'h0000, 24'h020100, 1'b1};
    vt[18] = '{2'd0, 1'b0, 16'h0000, 1'b1, 16'h0007, 2'd3, 16'h0000, 24'h020100, 1'b1};
    vt[19] = '{2'd3, 1'b0, 16'h0000, 1'b1, 16'h000A, 2'd3, 16'h0003, 24'h050403, 1'b1};
`ifdef IFETCH_BYPASS_EN
    // First response into an empty queue is visible in its arrival cycle.
    vt[0].avail = 2'd3;  vt[0].data = 24'h020100;
    vt[14].avail = 2'd3; vt[14].data = 24'h00FFFE; vt[14].cd = 1'b1;
`endif

    reset       = 1'b1;
    consume     = 2'd0;
    redirect    = 1'b0;
    redirect_pc = 16'h0000;
    iread_valid = 1'b1;
    #12;
    reset = 1'b0;
    #1;
    chk("reset_addr",  32'(iread_addr),  32'h4000);
    chk("reset_avail", 32'(instr_avail), 32'd0);
    chk("reset_pc",    32'(instr_pc),    32'h4000);
    chk("reset_data",  32'(instr_data),  32'h0);

    for (int i = 0; i < 20; i++) begin
      consume     = vt[i].c;
      redirect    = vt[i].r;
      redirect_pc = vt[i].rpc;
      iread_valid = vt[i].v;
      tick();
      chk($sformatf("v%0d_addr", i),  32'(iread_addr),  32'(vt[i].addr));
      chk($sformatf("v%0d_avail", i), 32'(instr_avail), 32'(vt[i].avail));
      chk($sformatf("v%0d_pc", i),    32'(instr_pc),    32'(vt[i].pc));
      if (vt[i].cd) chk($sformatf("v%0d_data", i), 32'(instr_data), 32'(vt[i].data));
    end

    // Asynchronous reset while a fetch is in flight.
    consume     = 2'd0;
    redirect    = 1'b0;
    iread_valid = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    chk("arst_addr",  32'(iread_addr),  32'h4000);
    chk("arst_avail", 32'(instr_avail), 32'd0);
    chk("arst_pc",    32'(instr_pc),    32'h4000);
    chk("arst_data",  32'(instr_data),  32'h0);
    tick();
    @(negedge clk);
    iread_valid = 1'b0;
    reset       = 1'b0;
    tick();
    chk("rel1_addr",  32'(iread_addr),  32'h4003);
    chk("rel1_avail", 32'(instr_avail), 32'd0);
    iread_valid = 1'b1;
    tick();
    chk("rel2_addr",  32'(iread_addr),  32'h4006);
    chk("rel2_avail", 32'(instr_avail), 32'd3);
    chk("rel2_pc",    32'(instr_pc),    32'h4000);
    chk("rel2_data",  32'(instr_data),  32'h020100);

`ifdef IFETCH_BYPASS_EN
    redirect    = 1'b1;
    redirect_pc = 16'h1000;
    tick();
    redirect = 1'b0;
    tick();
    chk("byp_avail", 32'(instr_avail), 32'd3);
    chk("byp_data",  32'(instr_data),  32'h020100);
    chk("byp_pc",    32'(instr_pc),    32'h1000);
    consume = 2'd2;
    tick();
    consume = 2'd0;
    chk("byp_rem_avail", 32'(instr_avail),     32'd1);
    chk("byp_rem_byte",  32'(instr_data[7:0]), 32'h02);
    chk("byp_rem_pc",    32'(instr_pc),        32'h1002);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
